// File: rtl/reg_share_pkg.sv
// Shared types and default sizing for the register-sharing arbiter.
package reg_share_pkg;

  localparam int unsigned DefN     = 4;
  localparam int unsigned DefW     = 8;
  localparam int unsigned DefQuota = 4;

  typedef enum logic [0:0] {
    StIdle,
    StOwn
  } state_e;

  // Index width that stays at least one bit wide when n is 1.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bundle of the register-sharing arbiter.
interface reg_share_arbiter_if
  import reg_share_pkg::*;
#(
  parameter int unsigned N = DefN,
  parameter int unsigned W = DefW
) ();

  localparam int unsigned IdxW = idx_w(N);

  logic [N-1:0]    req;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    gnt;
  logic [W-1:0]    q;
  logic            busy;
  logic [IdxW-1:0] owner;

  modport slave (
    input  req,
    input  wdata,
    output gnt,
    output q,
    output busy,
    output owner
  );

  modport master (
    output req,
    output wdata,
    input  gnt,
    input  q,
    input  busy,
    input  owner
  );

endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning from ptr_i upward modulo N.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned IdxW = idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  // Scan from the far end back toward ptr_i so the closest hit is written last.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = N; k > 0; k--) begin
      cand = IdxW'((32'(ptr_i) + k - 1) % N);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared register,
// with a per-owner quota of consecutive grant cycles and gap-free handoff.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned W     = DefW,
  parameter int unsigned QUOTA = DefQuota
) (
  input logic                 clock,
  input logic                 reset,
  reg_share_arbiter_if.slave  bus
);

  localparam int unsigned     IdxW   = idx_w(N);
  localparam int unsigned     CntW   = idx_w(QUOTA);
  localparam logic [CntW-1:0] CntMax = CntW'(QUOTA - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(N - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    q_q;

  logic [IdxW-1:0] owner_inc;
  logic [IdxW-1:0] pick_ptr;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic            owner_req;
  logic            q_load;

  assign owner_inc = (owner_q == IdxMax) ? '0 : owner_q + 1'b1;
  assign owner_req = bus.req[owner_q];
  // While owning, the search is only used at release and starts just past the owner.
  assign pick_ptr  = (state_q == StOwn) ? owner_inc : ptr_q;

  rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d           = StOwn;
          owner_d           = pick_idx;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          cnt_d             = '0;
        end
      end
      StOwn: begin
        q_load = owner_req;
        if (owner_req && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          ptr_d = owner_inc;
          cnt_d = '0;
          if (pick_valid) begin
            owner_d         = pick_idx;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
          end else begin
            state_d = StIdle;
            owner_d = '0;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else if (q_load) begin
      q_q <= bus.wdata[owner_q*W +: W];
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.q     = q_q;
  assign bus.busy  = |gnt_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench: directed steps queue expected post-edge outputs, a monitor checks them.
module tb_reg_share_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] q;
    logic [1:0] owner;
    logic       g1;
  } exp_t;

  logic clock;
  logic reset;
  exp_t sb[$];
  int   vectors;
  int   miscompares;

  reg_share_arbiter_if #(.N(4), .W(8)) bus4 ();
  reg_share_arbiter_if #(.N(1), .W(8)) bus1 ();

  assign bus1.req   = bus4.req[0];
  assign bus1.wdata = bus4.wdata[7:0];

  reg_share_arbiter #(.N(4), .W(8), .QUOTA(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  reg_share_arbiter #(.N(1), .W(8), .QUOTA(2)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic [31:0] wd,
                      input logic [3:0] eg, input logic [7:0] eq, input logic [1:0] eo);
    exp_t e;
    @(negedge clock);
    reset      = rst;
    bus4.req   = r;
    bus4.wdata = wd;
    e.gnt   = eg;
    e.q     = eq;
    e.owner = eo;
    // A single requester is granted on exactly the edges where it requests.
    e.g1    = ~rst & r[0];
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if (bus4.gnt !== e.gnt) begin
          miscompares++;
          $display("FAIL gnt vec %0d: got %b want %b", vectors, bus4.gnt, e.gnt);
        end
        if (bus4.q !== e.q) begin
          miscompares++;
          $display("FAIL q vec %0d: got %h want %h", vectors, bus4.q, e.q);
        end
        if (bus4.busy !== (|e.gnt)) begin
          miscompares++;
          $display("FAIL busy vec %0d: got %b want %b", vectors, bus4.busy, |e.gnt);
        end
        if (bus4.owner !== e.owner) begin
          miscompares++;
          $display("FAIL owner vec %0d: got %0d want %0d", vectors, bus4.owner, e.owner);
        end
        if (bus1.gnt !== e.g1) begin
          miscompares++;
          $display("FAIL n1_gnt vec %0d: got %b want %b", vectors, bus1.gnt, e.g1);
        end
      end
    end
  end

  initial begin : stim
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus4.req    = '0;
    bus4.wdata  = '0;

    // Reset state, first grant and first write, quota re-grant of a lone requester.
    step(1, 4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 0);
    step(1, 4'b0001, 32'h0000_00A5, 4'b0000, 8'h00, 0);
    step(0, 4'b0001, 32'h0000_00A5, 4'b0001, 8'h00, 0);
    step(0, 4'b0001, 32'h0000_00A5, 4'b0001, 8'hA5, 0);
    step(0, 4'b0001, 32'h0000_0010, 4'b0001, 8'h10, 0);
    step(0, 4'b0001, 32'h0000_0011, 4'b0001, 8'h11, 0);
    step(0, 4'b0001, 32'h0000_0012, 4'b0001, 8'h12, 0);
    step(0, 4'b0001, 32'h0000_0013, 4'b0001, 8'h13, 0);
    step(0, 4'b0000, 32'h0000_0014, 4'b0000, 8'h13, 0);
    step(0, 4'b0000, 32'h0000_0015, 4'b0000, 8'h13, 0);

    // All four requesting: 4 cycles each, order 0,1,2,3,0.
    step(1, 4'b0000, 32'h4433_2211, 4'b0000, 8'h00, 0);
    step(0, 4'b1111, 32'h4433_2211, 4'b0001, 8'h00, 0);
    step(0, 4'b1111, 32'h4433_2211, 4'b0001, 8'h11, 0);
    step(0, 4'b1111, 32'h4433_2211, 4'b0001, 8'h11, 0);
    step(0, 4'b1111, 32'h4433_2211, 4'b0001, 8'h11, 0);
    step(0, 4'b1111, 32'h4433_2211, 4'b0010, 8'h11, 1);
    step(0, 4'b1111, 32'h4433_2211, 4'b0010, 8'h22, 1);
    step(0, 4'b1111, 32'h4433_2211, 4'b0010, 8'h22, 1);
    step(0, 4'b1111, 32'h4433_2211, 4'b0010, 8'h22, 1);
    step(0, 4'b1111, 32'h4433_2211, 4'b0100, 8'h22, 2);
    step(0, 4'b1111, 32'h4433_2211, 4'b0100, 8'h33, 2);
    step(0, 4'b1111, 32'h4433_2211, 4'b0100, 8'h33, 2);
    step(0, 4'b1111, 32'h4433_2211, 4'b0100, 8'h33, 2);
    step(0, 4'b1111, 32'h4433_2211, 4'b1000, 8'h33, 3);
    step(0, 4'b1111, 32'h4433_2211, 4'b1000, 8'h44, 3);
    step(0, 4'b1111, 32'h4433_2211, 4'b1000, 8'h44, 3);
    step(0, 4'b1111, 32'h4433_2211, 4'b1000, 8'h44, 3);
    step(0, 4'b1111, 32'h4433_2211, 4'b0001, 8'h44, 0);

    // Owner drop hands off on the same edge; late req[3] waits for the release.
    step(1, 4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 0);
    step(0, 4'b0010, 32'h0000_5A00, 4'b0010, 8'h00, 1);
    step(0, 4'b0100, 32'h0061_0000, 4'b0100, 8'h00, 2);
    step(0, 4'b1100, 32'h7061_0000, 4'b0100, 8'h61, 2);
    step(0, 4'b1000, 32'h7062_0000, 4'b1000, 8'h61, 3);
    step(0, 4'b1000, 32'h7000_0000, 4'b1000, 8'h70, 3);
    step(0, 4'b0000, 32'h7100_0000, 4'b0000, 8'h70, 0);

    // Reset mid-ownership aborts the grant and the write, then arbitration restarts.
    step(0, 4'b0010, 32'h0000_3C00, 4'b0010, 8'h70, 1);
    step(0, 4'b0010, 32'h0000_3C00, 4'b0010, 8'h3C, 1);
    step(1, 4'b0010, 32'h0000_FF00, 4'b0000, 8'h00, 0);
    step(0, 4'b0010, 32'h0000_FF00, 4'b0010, 8'h00, 1);
    step(0, 4'b0010, 32'h0000_FF00, 4'b0010, 8'hFF, 1);
    step(0, 4'b0000, 32'h0000_FF00, 4'b0000, 8'hFF, 0);

    // Quota expiry with another requester pending: expired owner ranks last.
    step(1, 4'b0000, 32'h002A_000A, 4'b0000, 8'h00, 0);
    step(0, 4'b0101, 32'h002A_000A, 4'b0001, 8'h00, 0);
    step(0, 4'b0101, 32'h002A_000A, 4'b0001, 8'h0A, 0);
    step(0, 4'b0101, 32'h002A_000A, 4'b0001, 8'h0A, 0);
    step(0, 4'b0101, 32'h002A_000A, 4'b0001, 8'h0A, 0);
    step(0, 4'b0101, 32'h002A_000A, 4'b0100, 8'h0A, 2);
    step(0, 4'b0101, 32'h002A_000A, 4'b0100, 8'h2A, 2);
    step(0, 4'b0101, 32'h002A_000A, 4'b0100, 8'h2A, 2);
    step(0, 4'b0101, 32'h002A_000A, 4'b0100, 8'h2A, 2);
    step(0, 4'b0101, 32'h002A_000A, 4'b0001, 8'h2A, 0);
    step(0, 4'b0000, 32'h002A_000A, 4'b0000, 8'h2A, 0);

    repeat (3) @(posedge clock);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
